// File: rtl/cont_load_pkg.sv
// Shared definitions for the load-counter command driver: level width, state encoding, defaults.
package cont_load_pkg;

    localparam int LEVEL_W        = 3;
    localparam int MAX_LEVEL      = (1 << LEVEL_W) - 1;
    localparam int STEP_LIMIT_DEF = 8;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/cont_load_model.sv
// Shadow of the external saturating counter: tracks the expected level and flags any disagreement on q or a.
module cont_load_model
    import cont_load_pkg::*;
#(
    parameter int W = LEVEL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_step,
    input  logic         i_up,
    input  logic [W-1:0] i_q,
    input  logic         i_a,
    output logic         o_mismatch
);

    localparam logic [W-1:0] MAX_Q = '1;

    logic [W-1:0] r_q_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_exp <= '0;
        end else if (i_load) begin
            r_q_exp <= i_load_val;
        end else if (i_step) begin
            // Clamp like the real counter; never wrap.
            if (i_up)
                r_q_exp <= (r_q_exp == MAX_Q) ? MAX_Q : r_q_exp + W'(1);
            else
                r_q_exp <= (r_q_exp == '0) ? '0 : r_q_exp - W'(1);
        end
    end

    assign o_mismatch = (i_q != r_q_exp) || (i_a != (i_q == MAX_Q));

endmodule

// File: rtl/cont_load_driver.sv
// Drives counter X until q reaches the target, checking every step; CONT_LOAD_HOLD_EN adds a dither-at-target HOLD state.
// States: IDLE drain, await start | RUN step toward target | HOLD dither at target | ERR fault latched
module cont_load_driver
    import cont_load_pkg::*;
#(
    parameter int W          = LEVEL_W,
    parameter int STEP_LIMIT = STEP_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic [W-1:0] q,
    input  logic         a,
    output logic         x,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int SW = $clog2(STEP_LIMIT + 1);

    state_t         r_state;
    state_t         w_state_nx;
    logic [W-1:0]   r_tgt;
    logic [SW-1:0]  r_step;
    logic           r_done;
    logic           r_err;

    logic           w_x;
    logic           w_accept;
    logic           w_step;
    logic           w_hit;
    logic           w_fault;
    logic           w_mismatch;

    cont_load_model #(.W(W)) u_model (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_accept),
        .i_load_val (q),
        .i_step     (w_step),
        .i_up       (w_x),
        .i_q        (q),
        .i_a        (a),
        .o_mismatch (w_mismatch)
    );

    always_comb begin
        w_state_nx = r_state;
        w_x        = 1'b0;
        w_accept   = 1'b0;
        w_step     = 1'b0;
        w_hit      = 1'b0;
        w_fault    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_accept = 1'b1;
            end
            ST_RUN: begin
                w_x = (q < r_tgt);
                if (w_mismatch) begin
                    w_fault    = 1'b1;
                    w_state_nx = ST_ERR;
                end else if (q == r_tgt) begin
                    w_hit = 1'b1;
`ifdef CONT_LOAD_HOLD_EN
                    w_state_nx = ST_HOLD;
`else
                    w_state_nx = ST_IDLE;
`endif
                end else if (r_step == SW'(STEP_LIMIT)) begin
                    w_fault    = 1'b1;
                    w_state_nx = ST_ERR;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_HOLD: begin
`ifdef CONT_LOAD_HOLD_EN
                // Up while at or below target keeps the counter bouncing tgt <-> tgt+1.
                w_x = (q <= r_tgt);
`endif
                if (start) w_accept = 1'b1;
            end
            ST_ERR: begin
                if (start) w_accept = 1'b1;
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_accept) w_state_nx = ST_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
            r_step  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_hit;
            if (w_accept) begin
                r_tgt  <= target;
                r_step <= '0;
                r_err  <= 1'b0;
            end else begin
                if (w_step)  r_step <= r_step + SW'(1);
                if (w_fault) r_err  <= 1'b1;
            end
        end
    end

    assign x    = w_x;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_cont_load_driver.sv
// Directed bench for cont_load_driver with a behavioural saturating counter in the loop.
module tb_cont_load_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] target;
    logic [2:0] cq = 3'd0;
    logic       a;
    logic       x, busy, done, err;

    logic       frz;
    logic       pre_en;
    logic [2:0] pre_val;
    logic       force_a0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // External counter: X=1 up, X=0 down, saturating; bench can preset or freeze it.
    always @(posedge clk) begin
        if (pre_en)
            cq <= pre_val;
        else if (!frz)
            cq <= x ? ((cq == 3'd7) ? 3'd7 : cq + 3'd1) : ((cq == 3'd0) ? 3'd0 : cq - 3'd1);
    end

    assign a = force_a0 ? 1'b0 : (cq == 3'd7);

    cont_load_driver dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .target (target),
        .q      (cq),
        .a      (a),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_q(input logic [2:0] v);
        frz     = 1'b1;
        pre_en  = 1'b1;
        pre_val = v;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] q0, input logic [2:0] tgt, input logic stuck,
                           output int nb, output int nx, output int nd,
                           output logic [2:0] lastq, output int first_done);
        set_q(q0);
        start  = 1'b1;
        target = tgt;
        tick();
        start  = 1'b0;
        frz    = stuck;
        nb = 0; nx = 0; nd = 0; lastq = 3'd0; first_done = -1;
        for (int i = 0; i < 14; i++) begin
            if (busy) begin
                nb++;
                lastq = cq;
                if (x) nx++;
            end
            if (done) begin
                nd++;
                if (first_done < 0) first_done = i;
            end
            tick();
        end
    endtask

    int         nb, nx, nd, fd;
    logic [2:0] lq;

    initial begin
        reset = 1'b1; start = 1'b0; target = 3'd0;
        frz = 1'b1; pre_en = 1'b0; pre_val = 3'd0; force_a0 = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err",  err,  0);
        check("rst_x",    x,    0);
        reset = 1'b0;
        tick();

        // 0 -> 5
        run_cmd(3'd0, 3'd5, 1'b0, nb, nx, nd, lq, fd);
        check("up5_busy",  nb, 6);
        check("up5_x",     nx, 5);
        check("up5_done",  nd, 1);
        check("up5_donet", fd, 6);
        check("up5_q",     lq, 5);
        check("up5_err",   err, 0);

        // 7 -> 2
        run_cmd(3'd7, 3'd2, 1'b0, nb, nx, nd, lq, fd);
        check("dn2_busy",  nb, 6);
        check("dn2_x",     nx, 0);
        check("dn2_done",  nd, 1);
        check("dn2_donet", fd, 6);
        check("dn2_q",     lq, 2);
`ifdef CONT_LOAD_HOLD_EN
        check("dn2_hold", (cq == 3'd2) || (cq == 3'd3), 1);
`else
        check("dn2_drain", cq, 0);
`endif

        // already at target
        run_cmd(3'd3, 3'd3, 1'b0, nb, nx, nd, lq, fd);
        check("eq3_busy",  nb, 1);
        check("eq3_x",     nx, 0);
        check("eq3_done",  nd, 1);
        check("eq3_donet", fd, 1);

        // counter stuck at 1
        run_cmd(3'd1, 3'd4, 1'b1, nb, nx, nd, lq, fd);
        check("stk_busy", nb, 2);
        check("stk_done", nd, 0);
        check("stk_err",  err, 1);
        check("stk_bsy0", busy, 0);
        check("stk_x0",   x, 0);

        // full flag missing at 7
        force_a0 = 1'b1;
        run_cmd(3'd5, 3'd7, 1'b0, nb, nx, nd, lq, fd);
        check("afl_busy", nb, 3);
        check("afl_done", nd, 0);
        check("afl_err",  err, 1);
        force_a0 = 1'b0;
        run_cmd(3'd7, 3'd0, 1'b0, nb, nx, nd, lq, fd);
        check("clr_busy", nb, 8);
        check("clr_x",    nx, 0);
        check("clr_done", nd, 1);
        check("clr_q",    lq, 0);
        check("clr_err",  err, 0);

        // reset mid-RUN at q=3
        set_q(3'd0);
        start = 1'b1; target = 3'd6;
        tick();
        start = 1'b0; frz = 1'b0;
        tick(); tick(); tick();
        check("mr_q",    cq, 3);
        check("mr_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mr_busy0", busy, 0);
        check("mr_x0",    x, 0);
        check("mr_done0", done, 0);
        check("mr_err0",  err, 0);
        tick();
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) nd++;
            tick();
        end
        check("mr_nodone", nd, 0);

        // target = full scale
        run_cmd(3'd5, 3'd7, 1'b0, nb, nx, nd, lq, fd);
        check("full_done", nd, 1);
        check("full_busy", busy, 0);
`ifdef CONT_LOAD_HOLD_EN
        check("hold_x", x, 1);
        check("hold_q", cq, 7);
`else
        check("idle_x", x, 0);
        check("idle_q", cq, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
